uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `async_transmitter` UART TX between `NUM_REQ` byte-stream requesters. It grants one requester at a time and holds the grant for a whole frame, which ends on the byte flagged `req_last`. It feeds bytes through the transmitter's `TxD_start`/`TxD_busy` handshake. It sits between the scan-capture/debug sources and the single UART pin in the scan-inject test design.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TAG_BASE`, 8'hA0: base value of the source-tag byte (used only with `UART_ARB_TAG_EN`); the tag byte is `TAG_BASE | id`.

Ports (clock is `clk`; reset is `rst_n`, asynchronous, active-low):
- `clk` in 1: sole clock, shared with `async_transmitter`.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in NUM_REQ: requester i has a byte on its data lane.
- `req_data` in 8*NUM_REQ: byte lane i is `[8*i+7:8*i]`.
- `req_last` in NUM_REQ: the current byte of requester i ends its frame.
- `req_ready` out NUM_REQ: combinational, one-hot or zero; a byte is accepted when `req_valid[i] && req_ready[i]`.
- `TxD_start` out 1: one-cycle start pulse to the transmitter, registered.
- `TxD_data` out 8: byte to the transmitter, registered, valid while `TxD_start` is high.
- `TxD_busy` in 1: transmitter busy; rises the cycle after an accepted start.
- `grant_id` out clog2(NUM_REQ): index of the current grant holder, registered.
- `frame_active` out 1: high from grant until the last byte of the frame completes.

## Operation
- States: IDLE, TAG (only with the macro), SEND, ACK, DONE.
- IDLE:
  - The round-robin search starts at `rr_ptr` and picks the first i with `req_valid[i]`.
  - Next cycle: `grant_id`=i, `frame_active`=1, state moves to TAG (macro) or SEND.
  - With no valid requester, stay in IDLE.
- SEND:
  - When `TxD_busy`=0 and `req_valid[grant_id]`=1: `req_ready[grant_id]`=1 in that cycle.
  - The byte is registered into `TxD_data`, with `TxD_start`=1 on the next cycle; the `req_last` value is captured; state moves to ACK.
  - Otherwise stall; no timeout.
- TAG: same as SEND, but sends `TAG_BASE | grant_id`, asserts no `req_ready`, and returns to SEND after the DONE phase.
- ACK: wait for `TxD_busy`=1, then go to DONE.
- DONE: wait for `TxD_busy`=0.
  - If the captured last flag is set: go to IDLE, drop `frame_active`, set `rr_ptr` = (`grant_id`+1) mod NUM_REQ.
  - Else go to SEND.
- Grant is locked for the frame. Other requesters' `req_valid` is ignored until IDLE; `req_ready` stays 0 for them.
- Dropping `req_valid` mid-frame stalls in SEND with the grant held.
- `TxD_start` is never asserted while `TxD_busy`=1 or during ACK/DONE. At most one byte is in flight.
- Reset values: state IDLE, `rr_ptr`=0, `grant_id`=0, `frame_active`=0, `TxD_start`=0, `TxD_data`=8'h00, `req_ready`=0.
- Reset mid-frame aborts immediately; the partially sent frame is not resumed. The transmitter finishes its byte independently.

## Timing
- `req_valid` rises in cycle 0 with the arbiter idle and the transmitter idle:
  - grant in cycle 1 and `req_ready` in cycle 1 (no tag);
  - `TxD_start` in cycle 2.
- The tag adds one full byte time before the first data byte.
- Inter-byte gap after `TxD_busy` falls: 1 cycle to SEND, plus 1 cycle to `TxD_start`.
- IDLE to IDLE after a 1-byte frame: 2 cycles + 1 byte time + 1 cycle.
- Simultaneous requests in one cycle: the lowest index at or after `rr_ptr` wins. `rr_ptr` wraps from NUM_REQ-1 to 0.
- A requester re-requesting immediately after its frame loses to any other valid requester.

## Configuration
- `UART_ARB_TAG_EN` defined: every frame is prefixed with the tag byte `TAG_BASE | grant_id`, via the TAG state.
- Not defined: the TAG state and its logic are absent; frames are sent raw; timing as above without the tag.

## Structure
- Shared package `uart_arb_pkg`: state enum (IDLE/TAG/SEND/ACK/DONE), default `TAG_BASE`, byte width constant 8.
- One sub-module: `rr_picker`. It is combinational: inputs request vector and pointer; outputs found flag and index. The FSM and datapath stay in `uart_tx_arbiter`.
- The bench instantiates `uart_tx_arbiter` with the real `async_transmitter`, plus a behavioral busy model for fast runs.

## Test plan
- Single requester 0 sends the frame 8'h55, 8'hAA(last) → `TxD_start` pulses carry 0x55 then 0xAA, one pulse per busy period; `frame_active` falls after the second busy ends; `rr_ptr`=1.
- Requesters 1 and 3 valid in the same cycle with `rr_ptr`=2 → 3 granted first; 1 is granted after 3's last byte.
- Requester 2 sends a 3-byte frame while 0 asserts valid throughout → 0 gets no `req_ready` until 2's last byte completes.
- Requester drops `req_valid` for 10 cycles mid-frame → no `TxD_start` during the gap; grant held; resumes with the next byte.
- `rst_n` pulsed low during ACK → all outputs at reset values asynchronously; the next request is granted from `rr_ptr`=0.
- With `UART_ARB_TAG_EN`, requester 1 sends 8'h12(last) → transmitted bytes are 8'hA1, then 8'h12.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART TX arbiter slice.
//   BYTE_W           : width of one transmitted byte
//   TAG_BASE_DEFAULT : default base value of the source-tag byte
//   arbState_t       : arbiter FSM state encoding
package uart_arb_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] TAG_BASE_DEFAULT = 8'hA0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        TAG  = 3'd1,
        SEND = 3'd2,
        ACK  = 3'd3,
        DONE = 3'd4
    } arbState_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker.
// Scans the request vector starting at ptr, wrapping from NUM_REQ-1 to 0,
// and reports the first set position.
//   reqVec : request vector, one bit per requester
//   ptr    : index at which the scan starts (must be < NUM_REQ)
//   found  : at least one request is set
//   idx    : index of the winning request (0 when found is low)
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] reqVec,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    int j;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!found && reqVec[ID_W'(j)]) begin
                found = 1'b1;
                idx   = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter and byte sequencer sharing one UART transmitter
// between NUM_REQ byte-stream requesters. A grant is held for a whole
// frame (terminated by the byte flagged req_last); bytes are handed to
// the transmitter through its TxD_start / TxD_busy handshake, one in flight.
//
// Optional feature macro: UART_ARB_TAG_EN
//   When defined, every frame is prefixed with the tag byte TAG_BASE | grant_id.
//
// Ports:
//   clk          : clock, shared with the transmitter
//   rst_n        : asynchronous active-low reset
//   req_valid    : per-requester byte valid
//   req_data     : byte lanes, lane i = [8*i+7:8*i]
//   req_last     : per-requester end-of-frame flag for the current byte
//   req_ready    : combinational accept, one-hot or zero
//   TxD_start    : registered one-cycle start pulse to the transmitter
//   TxD_data     : registered byte, valid while TxD_start is high
//   TxD_busy     : transmitter busy, rises the cycle after an accepted start
//   grant_id     : registered index of the current grant holder
//   frame_active : high from grant until the frame's last byte completes
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int                 NUM_REQ  = 4,
    parameter logic [BYTE_W-1:0]  TAG_BASE = TAG_BASE_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        TxD_start,
    output logic [BYTE_W-1:0]           TxD_data,
    input  logic                        TxD_busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        frame_active
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    // The tag byte ORs the requester index into TAG_BASE, so the low
    // index bits of TAG_BASE have to be clear for the tag to be decodable.
    if (TAG_BASE[ID_W-1:0] != '0) begin : gTagBaseCheck
        $error("TAG_BASE low index bits must be zero");
    end

    arbState_t          state, stateNext;
    logic [ID_W-1:0]    rrPtr, rrPtrNext;
    logic [ID_W-1:0]    grantIdNext;
    logic               frameActiveNext;
    logic               txStartNext;
    logic [BYTE_W-1:0]  txDataNext;
    logic               lastFlag, lastFlagNext;

    logic               pickFound;
    logic [ID_W-1:0]    pickIdx;

    logic               grantValid;
    logic               grantLast;
    logic [BYTE_W-1:0]  grantByte;
    logic [ID_W-1:0]    nextPtr;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) uPicker (
        .reqVec (req_valid),
        .ptr    (rrPtr),
        .found  (pickFound),
        .idx    (pickIdx)
    );

    // Lane of the current grant holder.
    assign grantValid = req_valid[grant_id];
    assign grantLast  = req_last[grant_id];
    assign grantByte  = req_data[{grant_id, 3'b000} +: BYTE_W];
    assign nextPtr    = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rrPtr        <= '0;
            grant_id     <= '0;
            frame_active <= 1'b0;
            TxD_start    <= 1'b0;
            TxD_data     <= '0;
            lastFlag     <= 1'b0;
        end else begin
            state        <= stateNext;
            rrPtr        <= rrPtrNext;
            grant_id     <= grantIdNext;
            frame_active <= frameActiveNext;
            TxD_start    <= txStartNext;
            TxD_data     <= txDataNext;
            lastFlag     <= lastFlagNext;
        end
    end

    always_comb begin
        stateNext       = state;
        rrPtrNext       = rrPtr;
        grantIdNext     = grant_id;
        frameActiveNext = frame_active;
        txStartNext     = 1'b0;
        txDataNext      = TxD_data;
        lastFlagNext    = lastFlag;
        req_ready       = '0;

        case (state)
            IDLE: begin
                if (pickFound) begin
                    grantIdNext     = pickIdx;
                    frameActiveNext = 1'b1;
`ifdef UART_ARB_TAG_EN
                    stateNext       = TAG;
`else
                    stateNext       = SEND;
`endif
                end
            end

`ifdef UART_ARB_TAG_EN
            // Tag byte: never the last byte, so DONE always returns to SEND.
            TAG: begin
                if (!TxD_busy) begin
                    txStartNext  = 1'b1;
                    txDataNext   = TAG_BASE | {{(BYTE_W-ID_W){1'b0}}, grant_id};
                    lastFlagNext = 1'b0;
                    stateNext    = ACK;
                end
            end
`endif

            SEND: begin
                if (!TxD_busy && grantValid) begin
                    req_ready[grant_id] = 1'b1;
                    txStartNext         = 1'b1;
                    txDataNext          = grantByte;
                    lastFlagNext        = grantLast;
                    stateNext           = ACK;
                end
            end

            ACK: begin
                if (TxD_busy) begin
                    stateNext = DONE;
                end
            end

            DONE: begin
                if (!TxD_busy) begin
                    if (lastFlag) begin
                        stateNext       = IDLE;
                        frameActiveNext = 1'b0;
                        rrPtrNext       = nextPtr;
                    end else begin
                        stateNext = SEND;
                    end
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule
